// File: rtl/cla_four.sv
// cla_four: 4-bit carry-lookahead adder slice.
// Carries come straight from per-bit generate/propagate terms in two logic
// levels. The group generate/propagate outputs allow several slices to be
// cascaded under a second-level lookahead unit.
// REG_OUT selects between registered outputs (1-cycle latency) and a purely
// combinational path.
module cla_four #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       gg,
    output logic       pg,
    output logic       out_valid
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] s_c;
    logic       gg_c;
    logic       pg_c;

    // Per-bit generate and propagate terms.
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign g[i]   = a[i] & b[i];
        assign p[i]   = a[i] ^ b[i];
        assign s_c[i] = p[i] ^ c[i];
    end

    // Each carry is a flat sum of products of g/p/cin, so there is no ripple chain.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    // The group terms do not depend on cin, so c[4] == gg_c | (pg_c & cin).
    assign gg_c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign pg_c = &p;

    if (REG_OUT) begin : g_reg
        // Registered outputs. The data registers load every cycle and only the
        // valid bit is qualified by in_valid. Reset takes priority over in_valid.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s         <= 4'b0000;
                cout      <= 1'b0;
                gg        <= 1'b0;
                pg        <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                s         <= s_c;
                cout      <= c[4];
                gg        <= gg_c;
                pg        <= pg_c;
                out_valid <= in_valid;
            end
        end
    end else begin : g_comb
        // In the combinational variant the clock and reset have no effect.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};
        assign s         = s_c;
        assign cout      = c[4];
        assign gg        = gg_c;
        assign pg        = pg_c;
        assign out_valid = in_valid;
    end

endmodule

// File: tb/tb_cla_four.sv
// Testbench for cla_four. A registered instance and a combinational instance
// receive the same stimulus. Both are checked against an arithmetic reference
// that packs {out_valid, pg, gg, cout, s} into one byte.
module tb_cla_four;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;

    logic [3:0] s_r, s_c;
    logic       cout_r, cout_c, gg_r, gg_c, pg_r, pg_c, ov_r, ov_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_four #(.REG_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .s(s_r), .cout(cout_r), .gg(gg_r), .pg(pg_r), .out_valid(ov_r)
    );

    cla_four #(.REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
        .s(s_c), .cout(cout_c), .gg(gg_c), .pg(pg_c), .out_valid(ov_c)
    );

    // Reference: the sum is plain addition.
    // gg is set when a+b alone overflows 4 bits.
    // pg is set when a+b is exactly 15, which means a and b share no set bits.
    function automatic logic [7:0] ref_res(input logic [3:0] ra, input logic [3:0] rb,
                                           input logic rc, input logic rv);
        int         ab;
        int         sum;
        logic [4:0] s5;
        ab  = int'(ra) + int'(rb);
        sum = ab + int'(rc);
        s5  = 5'(sum);
        return {rv, (ab == 15), (ab > 15), s5};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got {ov,pg,gg,cout,s}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one vector on the falling edge and check the combinational instance.
    // After the rising edge, check the registered instance.
    task automatic step(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic vc, input logic vv, input logic vr);
        logic [7:0] e;
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = vv; rst_n = vr;
        e = ref_res(va, vb, vc, vv);
        #1;
        chk({tag, "/comb"}, {ov_c, pg_c, gg_c, cout_c, s_c}, e);
        @(posedge clk);
        #1;
        if (!vr) e = 8'h00;
        chk({tag, "/reg"}, {ov_r, pg_r, gg_r, cout_r, s_r}, e);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 4'h0; b = 4'h0; cin = 1'b0;

        // Reset held for two cycles with every input at its maximum.
        step("reset0", 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
        step("reset1", 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);

        // Directed vectors with cin=0.
        step("d0_0", 4'b0110, 4'b0010, 1'b0, 1'b1, 1'b1);
        step("d0_1", 4'b1100, 4'b0010, 1'b0, 1'b1, 1'b1);
        step("d0_2", 4'b0011, 4'b1001, 1'b0, 1'b1, 1'b1);
        step("d0_3", 4'b0110, 4'b1111, 1'b0, 1'b1, 1'b1);
        step("d0_4", 4'b0011, 4'b1011, 1'b0, 1'b1, 1'b1);
        step("d0_5", 4'b1001, 4'b1100, 1'b0, 1'b1, 1'b1);

        // Directed vectors with cin=1.
        step("d1_0", 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1);
        step("d1_1", 4'b0110, 4'b0010, 1'b1, 1'b1, 1'b1);
        step("d1_2", 4'b0110, 4'b1111, 1'b1, 1'b1, 1'b1);
        step("d1_3", 4'b1001, 4'b1100, 1'b1, 1'b1, 1'b1);
        step("d1_4", 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1);

        // Group generate/propagate cases, with cin toggled.
        step("grp_g",  4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1);
        step("grp_p0", 4'b1010, 4'b0101, 1'b0, 1'b1, 1'b1);
        step("grp_p1", 4'b1010, 4'b0101, 1'b1, 1'b1, 1'b1);

        // Back-to-back random stream with toggling in_valid and occasional resets.
        for (int i = 0; i < 300; i++) begin
            logic r;
            r = ($urandom_range(0, 19) != 0);
            step("rand", 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), r);
        end

        // Mid-stream reset: the in-flight result is discarded and the next input is valid one cycle later.
        step("mid_pre",  4'b0111, 4'b0001, 1'b0, 1'b1, 1'b1);
        step("mid_rst",  4'b0111, 4'b0001, 1'b0, 1'b1, 1'b0);
        step("mid_post", 4'b0101, 4'b0011, 1'b1, 1'b1, 1'b1);

        // Exhaustive sweep over every (a, b, cin) combination.
        for (int k = 0; k < 512; k++) begin
            logic [8:0] kv;
            kv = 9'(k);
            step("exh", kv[3:0], kv[7:4], kv[8], kv[0] ^ kv[5], 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
